// File: rtl/sm3_msg_feeder.sv
// SM3 message feeder: packs a host byte stream big-endian into 32-bit core words,
// drives the core enable/word handshake and holds the captured digest for the host.
module sm3_msg_feeder (
  input  logic         clk_in,
  input  logic         reset_n_in,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid_in,
  input  logic         byte_last_in,
  output logic         byte_ready_out,
  output logic         SM3_en_out,
  output logic [31:0]  msg_out,
  output logic         msg_valid_out,
  input  logic         msg_ready_in,
  output logic         is_last_word_out,
  output logic [1:0]   last_word_byte_out,
  input  logic [127:0] sm3_result_in,
  input  logic         sm3_finished_in,
  output logic [127:0] result_out,
  output logic         result_valid_out,
  input  logic         result_ack_in
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PACK      = 2'd1,
    WAIT_HASH = 2'd2,
    RESULT    = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [31:0]    pack_r, pack_s;
  logic [2:0]     cnt_r, cnt_s;
  logic           last_pend_r, last_pend_s;
  logic [31:0]    msg_r, msg_s;
  logic           msg_valid_r, msg_valid_s;
  logic           is_last_r, is_last_s;
  logic [1:0]     lwb_r, lwb_s;
  logic           en_r, en_s;
  logic           ready_r, ready_s;
  logic           fin_q_r;
  logic [127:0]   result_r, result_s;
  logic           result_valid_r, result_valid_s;

  logic           accept_s;
  logic           retire_s;
  logic           out_free_s;
  logic           fin_rise_s;
  logic           word_rdy_s;
  logic [31:0]    ins_s;
  logic [31:0]    pack_word_s;
  logic [2:0]     pack_cnt_s;
  logic           pack_last_s;

  assign accept_s    = byte_valid_in & ready_r;
  assign retire_s    = msg_valid_r & msg_ready_in;
  assign out_free_s  = ~msg_valid_r | retire_s;
  assign fin_rise_s  = sm3_finished_in & ~fin_q_r;
  assign pack_word_s = accept_s ? (pack_r | ins_s) : pack_r;
  assign pack_cnt_s  = cnt_r + {2'b00, accept_s};
  assign pack_last_s = last_pend_r | (accept_s & byte_last_in);
  // A word is complete at four bytes, or earlier when the message ends.
  assign word_rdy_s  = (pack_cnt_s == 3'd4) | (pack_last_s & (pack_cnt_s != 3'd0));

  // Place the incoming byte in the next free lane, MSB first.
  always_comb begin
    case (cnt_r[1:0])
      2'd0:    ins_s = {byte_in, 24'h000000};
      2'd1:    ins_s = {8'h00, byte_in, 16'h0000};
      2'd2:    ins_s = {16'h0000, byte_in, 8'h00};
      2'd3:    ins_s = {24'h000000, byte_in};
      default: ins_s = 32'h0000_0000;
    endcase
  end

  // Pack register and output word register; a completed word moves across when the output frees.
  always_comb begin
    pack_s      = pack_r;
    cnt_s       = cnt_r;
    last_pend_s = last_pend_r;
    msg_s       = msg_r;
    msg_valid_s = msg_valid_r;
    is_last_s   = is_last_r;
    lwb_s       = lwb_r;
    if (word_rdy_s && out_free_s) begin
      msg_s       = pack_word_s;
      msg_valid_s = 1'b1;
      is_last_s   = pack_last_s;
      lwb_s       = pack_last_s ? pack_cnt_s[1:0] : 2'b00;
      pack_s      = 32'h0000_0000;
      cnt_s       = 3'd0;
      last_pend_s = 1'b0;
    end else begin
      if (retire_s) begin
        msg_valid_s = 1'b0;
        is_last_s   = 1'b0;
        lwb_s       = 2'b00;
      end else begin
        msg_valid_s = msg_valid_r;
      end
      pack_s      = pack_word_s;
      cnt_s       = pack_cnt_s;
      last_pend_s = pack_last_s;
    end
  end

  // Message sequencing, digest capture and the registered byte-ready decision.
  always_comb begin
    state_s        = state_r;
    en_s           = en_r;
    result_s       = result_r;
    result_valid_s = result_valid_r;
    ready_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = PACK;
          en_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      PACK: begin
        if (retire_s && is_last_r) begin
          state_s = WAIT_HASH;
        end else begin
          state_s = PACK;
        end
      end
      WAIT_HASH: begin
        if (fin_rise_s) begin
          state_s        = RESULT;
          result_s       = sm3_result_in;
          result_valid_s = 1'b1;
          en_s           = 1'b0;
        end else begin
          state_s = WAIT_HASH;
        end
      end
      RESULT: begin
        if (result_ack_in) begin
          state_s        = IDLE;
          result_s       = 128'h0;
          result_valid_s = 1'b0;
        end else begin
          state_s = RESULT;
        end
      end
      default: begin
        state_s        = IDLE;
        en_s           = 1'b0;
        result_s       = 128'h0;
        result_valid_s = 1'b0;
      end
    endcase
    // Stop taking bytes once the last byte is in, or while a full word waits behind a busy output.
    if (state_s == IDLE) begin
      ready_s = 1'b1;
    end else if (state_s == PACK) begin
      ready_s = ~(last_pend_s | is_last_s) & ~((cnt_s == 3'd4) & msg_valid_s);
    end else begin
      ready_s = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_r        <= IDLE;
      pack_r         <= 32'h0000_0000;
      cnt_r          <= 3'd0;
      last_pend_r    <= 1'b0;
      msg_r          <= 32'h0000_0000;
      msg_valid_r    <= 1'b0;
      is_last_r      <= 1'b0;
      lwb_r          <= 2'b00;
      en_r           <= 1'b0;
      ready_r        <= 1'b0;
      fin_q_r        <= 1'b0;
      result_r       <= 128'h0;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      pack_r         <= pack_s;
      cnt_r          <= cnt_s;
      last_pend_r    <= last_pend_s;
      msg_r          <= msg_s;
      msg_valid_r    <= msg_valid_s;
      is_last_r      <= is_last_s;
      lwb_r          <= lwb_s;
      en_r           <= en_s;
      ready_r        <= ready_s;
      fin_q_r        <= sm3_finished_in;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
    end
  end

  assign byte_ready_out     = ready_r;
  assign SM3_en_out         = en_r;
  assign msg_out            = msg_r;
  assign msg_valid_out      = msg_valid_r;
  assign is_last_word_out   = is_last_r;
  assign last_word_byte_out = lwb_r;
  assign result_out         = result_r;
  assign result_valid_out   = result_valid_r;

endmodule

// File: doc/sm3_msg_feeder.md
# sm3_msg_feeder

Host-side source for the SM3 hash core's word interface. Accepts a byte stream from the host with valid/ready flow control and packs it big-endian into 32-bit words. Drives the core's enable, word-valid, last-word and last-word-byte-count inputs, then captures the core's 128-bit folded digest and holds it for the host until acknowledged. Sits between the host bus adapter and the SM3 core, one instance per core.

## Interface
Parameters:
- none; core word width fixed at 32, digest width fixed at 128.

Ports:
- clk_in  input  1  single clock; all logic on rising edge.
- reset_n_in  input  1  reset, synchronous, active-low.
- byte_in  input  8  host message byte.
- byte_valid_in  input  1  byte_in valid.
- byte_last_in  input  1  qualifies byte_in as final byte of message.
- byte_ready_out  output  1  feeder accepts byte this cycle.
- SM3_en_out  output  1  core enable, high for the whole message.
- msg_out  output  32  packed word to core, first byte in [31:24].
- msg_valid_out  output  1  msg_out valid.
- msg_ready_in  input  1  core takes msg_out this cycle.
- is_last_word_out  output  1  msg_out is final word.
- last_word_byte_out  output  2  valid bytes in final word mod 4 (00=4, 01=1, 10=2, 11=3); 00 when not last.
- sm3_result_in  input  128  core digest.
- sm3_finished_in  input  1  core completion flag (level).
- result_out  output  128  captured digest.
- result_valid_out  output  1  result_out valid.
- result_ack_in  input  1  host consumed result.

## Operation
- States: IDLE, PACK, WAIT_HASH, RESULT.
- IDLE: byte_ready_out=1. First accepted byte goes to PACK and sets SM3_en_out.
- Byte accepted when byte_valid_in && byte_ready_out.
- Pack register: 32-bit shift plus 2-bit byte count. Each accepted byte shifts in at the next free position, MSB first.
- Output register: msg_out, msg_valid_out, is_last_word_out, last_word_byte_out. A word moves into it when the pack count reaches 4, or when the last byte is accepted. Unused low bytes are zero.
- Output word retires when msg_valid_out && msg_ready_in. It holds stable while stalled.
- byte_ready_out=0 when the pack register holds 4 bytes and the output register is occupied. A full pack word transfers in the same cycle the output retires.
- byte_ready_out=0 from acceptance of the last byte until return to IDLE.
- When the last word retires, go to WAIT_HASH.
- WAIT_HASH: capture sm3_result_in on a 0->1 edge of sm3_finished_in, sampled against a registered copy. A level already high on entry is ignored. Then clear SM3_en_out and go to RESULT.
- RESULT: result_valid_out=1 and result_out held until result_ack_in. On ack, go to IDLE.
- SM3_en_out is low in RESULT and IDLE, so the core sees at least 1 low cycle between messages.
- Empty messages are unsupported. A message always ends on an accepted byte with byte_last_in=1.
- byte_last_in is ignored unless byte_valid_in=1.
- Reset mid-operation: all state is discarded and every output returns to its reset value on the next edge.

## Timing
- Reset values: byte_ready_out=0 during reset, 1 in the first IDLE cycle after it. SM3_en_out=0, msg_out=0, msg_valid_out=0, is_last_word_out=0, last_word_byte_out=00, result_out=0, result_valid_out=0.
- SM3_en_out rises 1 cycle after the first byte is accepted.
- Latency: msg_valid_out rises 1 cycle after acceptance of a word's 4th byte, or of the last byte.
- A full-throughput stream with msg_ready_in=1 sustains 1 byte/cycle with no bubbles.
- Capture: result_valid_out and SM3_en_out=0 occur 1 cycle after the sm3_finished_in rising edge.
- The ack cycle clears result_valid_out on the next edge. byte_ready_out=1 on that same edge.
- Simultaneous word retire and pack-full transfer: no lost or duplicated word.

## Test plan
- Send "abc" (0x61, 0x62, 0x63 with last) -> one word msg_out=0x61626300, is_last_word_out=1, last_word_byte_out=11.
- Send 0x01..0x04 with last on 0x04 -> single word 0x01020304, last_word_byte_out=00, is_last_word_out=1.
- Send 9 bytes 0x10..0x18 with msg_ready_in=0 for 10 cycles -> byte_ready_out drops after the 8th byte. Words 0x10111213, 0x14151617, then 0x18000000 with last_word_byte_out=01 arrive in order, each held stable while stalled.
- In WAIT_HASH, pulse sm3_finished_in with sm3_result_in=0x0123..CDEF -> result_valid_out=1 and SM3_en_out=0 one cycle later. result_out stays unchanged for 5 cycles without ack, then clears on ack.
- Enter WAIT_HASH with sm3_finished_in already high -> no capture until it falls and rises again.
- Assert reset_n_in=0 after 6 bytes -> next edge gives all outputs at reset values. A new 4-byte message then completes normally.
